// File: rtl/commit_trace_tx.sv
// commit_trace_tx
//   Transmit side of the commit-trace interface. Each retired instruction is
//   classified, numbered and queued in a small record FIFO. Queued records are
//   then serialized as 16-bit words over a valid/ready port.
// Ports
//   clk, rst          clock and synchronous active-high reset
//   commit_*          retiring instruction fields, qualified by commit_valid
//   tx_valid/tx_data  registered trace word; tx_last marks the record's final word
//   tx_ready          receiver handshake
//   full              record FIFO holds DEPTH entries
//   overflow          sticky: a commit was dropped because the FIFO was full
//   done              sticky: the HALT record has been fully transmitted
module commit_trace_tx #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned INUM_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [15:0] commit_pc,
    input  logic        commit_regwrite,
    input  logic [2:0]  commit_wreg,
    input  logic [15:0] commit_wdata,
    input  logic        commit_memread,
    input  logic        commit_memwrite,
    input  logic [15:0] commit_memaddr,
    input  logic [15:0] commit_memdata,
    input  logic        commit_halt,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        full,
    output logic        overflow,
    output logic        done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        K_NOP  = 3'd0,
        K_REG  = 3'd1,
        K_LD   = 3'd2,
        K_ST   = 3'd3,
        K_STU  = 3'd4,
        K_HALT = 3'd5
    } kind_t;

    typedef struct packed {
        kind_t       kind;
        logic [2:0]  wreg;
        logic [9:0]  inum;
        logic [15:0] pc;
        logic [15:0] wdata;
        logic [15:0] memaddr;
        logic [15:0] memdata;
    } rec_t;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PC, S_D0, S_D1, S_D2} state_t;

    function automatic logic [1:0] ndata(kind_t k);
        case (k)
            K_REG:       return 2'd1;
            K_LD, K_ST:  return 2'd2;
            K_STU:       return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

    // ST records carry the STU data list without its leading wdata word.
    function automatic logic [15:0] word_of(state_t s, rec_t r);
        logic [1:0] idx;
        idx = (r.kind == K_ST) ? 2'd1 : 2'd0;
        case (s)
            S_HDR:   return {r.kind, r.wreg, r.inum};
            S_PC:    return r.pc;
            S_D1:    idx = idx + 2'd1;
            S_D2:    idx = idx + 2'd2;
            default: ;
        endcase
        case (idx)
            2'd0:    return r.wdata;
            2'd1:    return r.memaddr;
            default: return r.memdata;
        endcase
    endfunction

    function automatic logic last_of(state_t s, rec_t r);
        case (s)
            S_PC:    return ndata(r.kind) == 2'd0;
            S_D0:    return ndata(r.kind) == 2'd1;
            S_D1:    return ndata(r.kind) == 2'd2;
            S_D2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    rec_t              mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, remain;
    logic [INUM_W-1:0] inum_q, inum_d;
    logic              halt_seen_q, halt_seen_d;
    logic              tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic [15:0]       tx_data_q, tx_data_d;
    logic              full_q, full_d, overflow_q, overflow_d, done_q, done_d;
    logic              accept, push, fire, pop;
    kind_t             kind_in;
    rec_t              rec_in, head, next_rec;

    always_comb begin
        if (commit_regwrite && commit_memwrite)     kind_in = K_STU;
        else if (commit_regwrite && commit_memread) kind_in = K_LD;
        else if (commit_regwrite)                   kind_in = K_REG;
        else if (commit_halt)                       kind_in = K_HALT;
        else if (commit_memwrite)                   kind_in = K_ST;
        else                                        kind_in = K_NOP;

        rec_in.kind    = kind_in;
        rec_in.wreg    = commit_wreg;
        rec_in.inum    = inum_q[9:0];
        rec_in.pc      = commit_pc;
        rec_in.wdata   = commit_wdata;
        rec_in.memaddr = commit_memaddr;
        rec_in.memdata = commit_memdata;

        accept = commit_valid && !halt_seen_q;
        push   = accept && (count_q != CNT_W'(DEPTH));
        head   = mem_q[rd_ptr_q];
        fire   = tx_valid_q && tx_ready;
        pop    = fire && tx_last_q;

        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        inum_d      = accept ? inum_q + INUM_W'(1) : inum_q;
        halt_seen_d = halt_seen_q || (push && kind_in == K_HALT);
        overflow_d  = overflow_q || (accept && !push);
        done_d      = done_q || (pop && head.kind == K_HALT);
        full_d      = (count_d == CNT_W'(DEPTH));

        state_d = state_q;
        case (state_q)
            S_IDLE: if (count_d != '0) state_d = S_HDR;
            default: begin
                if (fire) begin
                    if (tx_last_q)             state_d = (count_d != '0) ? S_HDR : S_IDLE;
                    else if (state_q == S_HDR) state_d = S_PC;
                    else if (state_q == S_PC)  state_d = S_D0;
                    else if (state_q == S_D0)  state_d = S_D1;
                    else                       state_d = S_D2;
                end
            end
        endcase

        // Output words are registered, so they are computed from the entry that
        // will be at the head next cycle; a record pushed into an empty (or
        // emptying) FIFO is bypassed straight from the commit inputs.
        remain   = count_q - CNT_W'(pop);
        next_rec = (remain == '0) ? rec_in : mem_q[rd_ptr_d];

        tx_valid_d = (state_d != S_IDLE);
        tx_data_d  = tx_valid_d ? word_of(state_d, next_rec) : '0;
        tx_last_d  = tx_valid_d && last_of(state_d, next_rec);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rec_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            inum_q      <= '0;
            halt_seen_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_last_q   <= 1'b0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            inum_q      <= inum_d;
            halt_seen_q <= halt_seen_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            tx_last_q   <= tx_last_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_last  = tx_last_q;
    assign full     = full_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
module tb_commit_trace_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [15:0] commit_pc;
    logic        commit_regwrite;
    logic [2:0]  commit_wreg;
    logic [15:0] commit_wdata;
    logic        commit_memread;
    logic        commit_memwrite;
    logic [15:0] commit_memaddr;
    logic [15:0] commit_memdata;
    logic        commit_halt;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_last;
    logic        tx_ready;
    logic        full;
    logic        overflow;
    logic        done;

    int          errors = 0;
    int          checks = 0;
    logic [16:0] exp_q[$];
    logic [15:0] m_inum;
    bit          m_halt;

    commit_trace_tx #(.DEPTH(4), .INUM_W(16)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_regwrite(commit_regwrite), .commit_wreg(commit_wreg),
        .commit_wdata(commit_wdata), .commit_memread(commit_memread),
        .commit_memwrite(commit_memwrite), .commit_memaddr(commit_memaddr),
        .commit_memdata(commit_memdata), .commit_halt(commit_halt),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
        .tx_ready(tx_ready), .full(full), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted word is compared against the next expected one.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_word: observed=%h last=%b expected=none", tx_data, tx_last);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("word", {15'b0, tx_last, tx_data}, {15'b0, e});
            end
        end
    end

    task automatic do_reset();
        rst          = 1'b1;
        commit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_inum = '0;
        m_halt = 1'b0;
    endtask

    // Drives one commit for one cycle and records the words the receiver should see.
    task automatic do_commit(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                             input logic [15:0] wd, input logic mr, input logic mw,
                             input logic [15:0] ad, input logic [15:0] md,
                             input logic hl, input bit drop);
        logic [2:0]  k;
        logic [15:0] dw [3];
        int          nd;
        commit_valid    = 1'b1;
        commit_pc       = pc;
        commit_regwrite = rw;
        commit_wreg     = wr;
        commit_wdata    = wd;
        commit_memread  = mr;
        commit_memwrite = mw;
        commit_memaddr  = ad;
        commit_memdata  = md;
        commit_halt     = hl;
        if (rw && mw)      k = 3'd4;
        else if (rw && mr) k = 3'd2;
        else if (rw)       k = 3'd1;
        else if (hl)       k = 3'd5;
        else if (mw)       k = 3'd3;
        else               k = 3'd0;
        dw[0] = wd; dw[1] = ad; dw[2] = md; nd = 0;
        case (k)
            3'd1: nd = 1;
            3'd2: nd = 2;
            3'd4: nd = 3;
            3'd3: begin dw[0] = ad; dw[1] = md; nd = 2; end
            default: nd = 0;
        endcase
        if (!m_halt) begin
            if (!drop) begin
                exp_q.push_back({1'b0, k, wr, m_inum[9:0]});
                exp_q.push_back({(nd == 0), pc});
                for (int i = 0; i < nd; i++) exp_q.push_back({(i == nd - 1), dw[i]});
                if (k == 3'd5) m_halt = 1'b1;
            end
            m_inum = m_inum + 16'd1;
        end
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_regwrite = 1'b0;
        commit_wreg = '0; commit_wdata = '0; commit_memread = 1'b0; commit_memwrite = 1'b0;
        commit_memaddr = '0; commit_memdata = '0; commit_halt = 1'b0; tx_ready = 1'b0;
        m_inum = '0; m_halt = 1'b0;

        do_reset();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done", done, 0);

        // REG record, W0 visible the cycle after the commit
        tx_ready = 1'b1;
        do_commit(16'h0002, 1, 3'd3, 16'h1234, 0, 0, 16'h0, 16'h0, 0, 0);
        chk("reg_latency_valid", tx_valid, 1);
        chk("reg_w0", tx_data, 32'h2C00);
        drain();
        chk("reg_idle", tx_valid, 0);

        // STU record with inum 1
        do_commit(16'h0010, 1, 3'd1, 16'h00AA, 0, 1, 16'h0040, 16'h0055, 0, 0);
        chk("stu_w0", tx_data, 32'h8401);
        drain();

        // Fill with NOPs while stalled, fifth commit is dropped
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            do_commit(16'h0100 + 16'(i), 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
        chk("fill_full", full, 1);
        chk("fill_no_overflow", overflow, 0);
        do_commit(16'h0104, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1);
        chk("drop_overflow", overflow, 1);
        chk("drop_full", full, 1);
        tx_ready = 1'b1;
        drain();
        chk("drained_full", full, 0);
        do_commit(16'h0200, 1, 3'd2, 16'h0077, 0, 0, 16'h0, 16'h0, 0, 0);
        chk("gap_inum5_w0", tx_data, 32'h2805);
        drain();
        chk("overflow_sticky", overflow, 1);

        // Stall mid LD record on the wdata word
        tx_ready = 1'b0;
        do_commit(16'h0300, 1, 3'd5, 16'hBEEF, 1, 0, 16'h0400, 16'h0, 0, 0);
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", tx_valid, 1);
            chk("stall_data", tx_data, 32'hBEEF);
            chk("stall_last", tx_last, 0);
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        drain();

        // HALT then two REG commits that must be ignored
        do_commit(16'h0020, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0);
        chk("halt_w0", tx_data, 32'hA007);
        chk("halt_done_early", done, 0);
        do_commit(16'h0030, 1, 3'd1, 16'h1111, 0, 0, 16'h0, 16'h0, 0, 0);
        do_commit(16'h0032, 1, 3'd2, 16'h2222, 0, 0, 16'h0, 16'h0, 0, 0);
        drain();
        chk("halt_done", done, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("halt_quiet", tx_valid, 0);
        chk("halt_done_sticky", done, 1);

        // Reset in the middle of an ST record with entries queued
        do_reset();
        tx_ready = 1'b0;
        do_commit(16'h0500, 0, 3'd0, 16'h0, 0, 1, 16'h0600, 16'h0700, 0, 0);
        for (int i = 0; i < 3; i++)
            do_commit(16'h0510 + 16'(i), 1, 3'd6, 16'h0042, 0, 0, 16'h0, 16'h0, 0, 0);
        do_commit(16'h0520, 1, 3'd6, 16'h0043, 0, 0, 16'h0, 16'h0, 0, 1);
        chk("pre_rst_full", full, 1);
        chk("pre_rst_overflow", overflow, 1);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("st_w1", tx_data, 32'h0500);
        tx_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", tx_valid, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_done", done, 0);
        rst = 1'b0;
        exp_q.delete();
        m_inum = '0;
        m_halt = 1'b0;
        tx_ready = 1'b1;
        do_commit(16'h0700, 1, 3'd4, 16'h0099, 0, 0, 16'h0, 16'h0, 0, 0);
        chk("post_rst_w0", tx_data, 32'h3000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
